// File: rtl/hamming_pkg.sv
// Shared definitions for the serial Hamming decoder family.
// Contents:
//   state_t        - frame receiver states (IDLE, SHIFT)
//   code_len(r)    - codeword length N = 2^r - 1
//   data_len(r)    - payload length K = N - r
//   is_pow2(p)     - true for parity-bit positions (1, 2, 4, ...)
//   r_legal(r)     - supported range of parity-bit counts
package hamming_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int R_MIN = 2;
  localparam int R_MAX = 6;

  function automatic int code_len(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int data_len(input int r);
    return (1 << r) - 1 - r;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  function automatic bit r_legal(input int r);
    return (r >= R_MIN) && (r <= R_MAX);
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for Hamming(2^R-1)
// codewords, optionally extended with an overall parity bit (SECDED=1).
// Ports:
//   i_code     - received codeword, bit p holds code position p (1..N);
//                bit N+1 holds the overall parity P0 when SECDED=1
//   o_syndrome - s[j] = XOR of all positions p in 1..N whose bit j is set
//   o_parity   - XOR of every received bit (including P0 when present)
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int R      = 3,
  parameter int SECDED = 0
) (
  input  logic [code_len(R)+SECDED:1] i_code,
  output logic [R-1:0]                o_syndrome,
  output logic                        o_parity
);

  localparam int N = code_len(R);

  always_comb begin
    o_syndrome = '0;
    for (int p = 1; p <= N; p++) begin
      for (int j = 0; j < R; j++) begin
        if (p[j]) begin
          o_syndrome[j] = o_syndrome[j] ^ i_code[p];
        end
      end
    end
  end

  assign o_parity = ^i_code;

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial Hamming(2^R-1, 2^R-1-R) decoder with optional SEC-DED extension.
// Codeword bits arrive one per clock while strobe is high (position 1
// first, P0 last when SECDED=1). The falling strobe closes the frame: a
// frame of the right length is decoded and presented with a one-cycle
// data_valid pulse; any other length produces a one-cycle frame_err pulse
// and leaves the previous outputs untouched.
// Ports:
//   clk               - single clock, rising edge
//   rst_n             - asynchronous active-low reset
//   strobe            - frame enable
//   d_hamm            - serial codeword bit (sampled while strobe=1)
//   data_out          - K corrected data bits, held between frames
//   data_valid        - one-cycle pulse per decoded frame
//   err_corrected     - single error corrected (valid with data_valid)
//   err_uncorrectable - double error detected, SECDED=1 only
//   frame_err         - one-cycle pulse on a wrong-length frame
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int R      = 3,
  parameter int SECDED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   strobe,
  input  logic                   d_hamm,
  output logic [data_len(R)-1:0] data_out,
  output logic                   data_valid,
  output logic                   err_corrected,
  output logic                   err_uncorrectable,
  output logic                   frame_err
);

  localparam int N  = code_len(R);
  localparam int K  = data_len(R);
  localparam int L  = N + SECDED;
  // Counter must reach L+1 so that overlong frames stay distinguishable.
  localparam int CW = $clog2(L + 2);

  if (!r_legal(R)) begin : g_bad_r
    $error("hamming_serial_decoder: R=%0d outside supported range", R);
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [L:1]      r_buf;
  logic            w_end_ok;
  logic            w_end_bad;

  logic [R-1:0]    w_syn;
  logic            w_par;
  logic            w_syn_nz;
  logic            w_flip;
  logic            w_corr;
  logic            w_unc;
  logic [K-1:0]    w_data_fix;

  // ---- Receive FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_end_ok    = 1'b0;
    w_end_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (strobe) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!strobe) begin
          w_state_nxt = IDLE;
          if (r_count == CW'(L)) begin
            w_end_ok = 1'b1;
          end else begin
            w_end_bad = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Count is 0 whenever the FSM is in IDLE, so the first strobed bit always
  // lands in position 1 and the count of received bits equals the next
  // write position minus one. It saturates at L+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (strobe) begin
      if (r_count <= CW'(L)) begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= '0;
    end
  end

  // Shift buffer is data only; bits beyond position L match no slot and
  // are dropped.
  always_ff @(posedge clk) begin
    if (strobe) begin
      for (int p = 1; p <= L; p++) begin
        if (r_count == CW'(p - 1)) begin
          r_buf[p] <= d_hamm;
        end
      end
    end
  end

  // ---- Decode ----
  hamming_syndrome #(
    .R      (R),
    .SECDED (SECDED)
  ) u_syndrome (
    .i_code     (r_buf),
    .o_syndrome (w_syn),
    .o_parity   (w_par)
  );

  assign w_syn_nz = |w_syn;
  // Without SECDED any nonzero syndrome is trusted. With SECDED a nonzero
  // syndrome is only a single error when overall parity also fails; with
  // good parity it is a double error and nothing is flipped.
  assign w_flip   = w_syn_nz & ((SECDED == 0) | w_par);
  // With SECDED, failed overall parity always means one error was fixed:
  // either the flipped position or P0 itself (s=0).
  assign w_corr   = (SECDED == 0) ? w_syn_nz : w_par;
  assign w_unc    = (SECDED != 0) & w_syn_nz & ~w_par;

  // Data bits are the non-power-of-two positions in ascending order. The
  // number of powers of two not above p is clog2(p+1), which gives the
  // packed data index directly.
  for (genvar p = 1; p <= N; p++) begin : g_extract
    if (!is_pow2(p)) begin : g_data
      assign w_data_fix[p - 1 - $clog2(p + 1)] =
        r_buf[p] ^ (w_flip && (w_syn == R'(p)));
    end
  end

  // ---- Output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out          <= '0;
      data_valid        <= 1'b0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      data_valid <= w_end_ok;
      frame_err  <= w_end_bad;
      if (w_end_ok) begin
        data_out          <= w_data_fix;
        err_corrected     <= w_corr;
        err_uncorrectable <= w_unc;
      end
    end
  end

endmodule
